snd_status_monitor: RTL and testbench
=====================================

// Module: snd_status_monitor
// PURPOSE
//  Avalon-MM slave that conditions the 5-bit status bus from the sound FPGA before the HPS
//  reads it: 2-FF synchroniser, per-bit programmable debounce, both-edge capture and a
//  maskable level interrupt. It sits between the raw in_port pins and the lightweight
//  HPS-to-FPGA bridge, and supersedes direct unsynchronised PIO sampling of that bus.
// PARAMETERS
//  WIDTH            5        number of status inputs
//  DEB_W            16       width of debounce limit register and per-bit counters
//  DEB_DEFAULT      1000     reset value of DEBOUNCE register (clk cycles)
// PORTS
//  clk        in   1        system clock; all logic on rising edge
//  reset      in   1        synchronous, active-high reset
//  address    in   2        register word address
//  read       in   1        Avalon read strobe
//  write      in   1        Avalon write strobe
//  writedata  in   32       write data
//  readdata   out  32       read data, valid 1 cycle after read
//  irq        out  1        level interrupt to HPS
//  in_port    in   WIDTH    asynchronous status inputs from sound FPGA
// BEHAVIOUR
//  Register map (unused bits read 0, writes ignored):
//   0 DATA     RO  [WIDTH-1:0] debounced stable value
//   1 IRQMASK  RW  [WIDTH-1:0] per-bit interrupt enable
//   2 EDGECAP  W1C [WIDTH-1:0] edge captured; write 1 clears, write 0 no effect
//   3 DEBOUNCE RW  [DEB_W-1:0] debounce limit L
//  Reset: readdata=0, irq=0, sync regs=0, stable=0, counters=0, IRQMASK=0, EDGECAP=0,
//   DEBOUNCE=DEB_DEFAULT. Reset in mid-debounce discards the count; no edge is logged.
//  Sync: s1<=in_port; s2<=s1. s2 is the only consumer of in_port.
//  Debounce, per bit i, each cycle:
//   s2[i]==stable[i]          -> cnt[i]<=0
//   else cnt[i]>=L            -> stable[i]<=s2[i]; cnt[i]<=0
//   else                      -> cnt[i]<=cnt[i]+1 (no wrap: saturates at max)
//   A glitch returning before the limit restarts count; stable never changes.
//   Latency pin change -> DATA change: 2 (sync) + L+1 cycles; L=0 gives 3 cycles.
//   DEBOUNCE rewritten mid-count: compare uses new L immediately (>= so cnt>L commits
//   next cycle).
//  Edge capture: stable[i] change (either direction) sets EDGECAP[i] in the same cycle the
//   change registers. Simultaneous W1C and new edge on same bit -> bit ends 1 (set wins).
//   Out-of-reset inputs held high produce a rising edge after 2+L+1 cycles (captured).
//  irq: registered, irq <= |(EDGECAP_next & IRQMASK_next); asserts 1 cycle after the
//   EDGECAP bit sets (or mask write), deasserts 1 cycle after clear/mask off.
//  Reads: readdata <= selected register when read=1, else holds last value; no read side
//   effects. Write and read in same cycle: read returns pre-write value.
//  Fixed latency 1 read, 0 write wait states; no waitrequest.
// TESTING
//  1 reset, in_port=5'h00, read 0..3 -> 0,0,0,1000; irq=0 throughout.
//  2 DEBOUNCE=4, in_port[2] 0->1 held -> DATA=5'h04 exactly 7 cycles later; EDGECAP=5'h04.
//  3 DEBOUNCE=4, in_port[0] pulse 3 cycles -> DATA stays 0, EDGECAP stays 0.
//  4 IRQMASK=5'h04 after test 2 -> irq=1 next cycle; write EDGECAP=5'h04 -> irq=0 next
//    cycle; write EDGECAP=5'h01 -> no change to bit 2.
//  5 W1C of bit 3 in same cycle bit 3 stable toggles -> EDGECAP[3]=1, irq per mask.
//  6 DEBOUNCE=100, bit 1 counting at 50, write DEBOUNCE=10 -> DATA[1] updates next
//    cycle; reset asserted mid-count -> all regs to reset values, no edge logged.

Source files
------------

// File: rtl/snd_status_monitor.sv
// Avalon-MM status conditioner for the sound FPGA status bus: 2-FF synchroniser,
// per-bit debounce, both-edge capture (W1C) and a maskable level interrupt.
module snd_status_monitor #(
    parameter int          WIDTH       = 5,
    parameter int          DEB_W       = 16,
    parameter int unsigned DEB_DEFAULT = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    input  logic [WIDTH-1:0] in_port
);

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK  = 2'd1;
    localparam logic [1:0] ADDR_EDGECAP  = 2'd2;
    localparam logic [1:0] ADDR_DEBOUNCE = 2'd3;

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_stable;
    logic [DEB_W-1:0] r_cnt [WIDTH];
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] r_edgecap;
    logic [DEB_W-1:0] r_deb;
    logic [31:0]      r_readdata;
    logic             r_irq;

    logic [WIDTH-1:0] w_stable_next;
    logic [DEB_W-1:0] w_cnt_next [WIDTH];
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_w1c;
    logic [WIDTH-1:0] w_irqmask_next;
    logic [WIDTH-1:0] w_edgecap_next;
    logic [31:0]      w_rd_mux;
    logic             w_unused;

    assign w_unused = &{1'b0, writedata[31:DEB_W]};

    // A counter only runs while the synchronised input disagrees with the
    // stable value; reaching the limit commits the new level.
    always_comb begin
        w_stable_next = r_stable;
        for (int i = 0; i < WIDTH; i++) begin
            w_cnt_next[i] = '0;
            if (r_s2[i] != r_stable[i]) begin
                if (r_cnt[i] >= r_deb) begin
                    w_stable_next[i] = r_s2[i];
                end else if (r_cnt[i] != '1) begin
                    w_cnt_next[i] = r_cnt[i] + 1'b1;
                end else begin
                    w_cnt_next[i] = r_cnt[i];
                end
            end
        end
    end

    assign w_edge         = w_stable_next ^ r_stable;
    assign w_w1c          = (write && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
    assign w_irqmask_next = (write && address == ADDR_IRQMASK) ? writedata[WIDTH-1:0] : r_irqmask;
    // Set wins over a simultaneous write-1-to-clear on the same bit.
    assign w_edgecap_next = (r_edgecap & ~w_w1c) | w_edge;

    always_comb begin
        w_rd_mux = '0;
        case (address)
            ADDR_DATA:     w_rd_mux[WIDTH-1:0] = r_stable;
            ADDR_IRQMASK:  w_rd_mux[WIDTH-1:0] = r_irqmask;
            ADDR_EDGECAP:  w_rd_mux[WIDTH-1:0] = r_edgecap;
            ADDR_DEBOUNCE: w_rd_mux[DEB_W-1:0] = r_deb;
            default:       w_rd_mux = '0;
        endcase
    end

    // NOTE: all state, including the per-bit counter array, is flops updated with
    // non-blocking assignments; the counters are not a RAM, so resetting them is fine.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1       <= '0;
            r_s2       <= '0;
            r_stable   <= '0;
            r_irqmask  <= '0;
            r_edgecap  <= '0;
            r_deb      <= DEB_W'(DEB_DEFAULT);
            r_readdata <= '0;
            r_irq      <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1      <= in_port;
            r_s2      <= r_s1;
            r_stable  <= w_stable_next;
            r_irqmask <= w_irqmask_next;
            r_edgecap <= w_edgecap_next;
            r_irq     <= |(w_edgecap_next & w_irqmask_next);
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= w_cnt_next[i];
            end
            if (write && address == ADDR_DEBOUNCE) begin
                r_deb <= writedata[DEB_W-1:0];
            end
            // The mux sees pre-write register values, so a same-cycle write is not visible.
            if (read) begin
                r_readdata <= w_rd_mux;
            end
        end
    end

    assign readdata = r_readdata;
    assign irq      = r_irq;

endmodule

// File: tb/tb_snd_status_monitor.sv
// Scoreboard bench for snd_status_monitor: a cycle-level behavioural model predicts
// read data and irq; a negedge monitor pops and compares.
module tb_snd_status_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic [4:0]  in_port;

    int n_checks = 0;
    int n_fail   = 0;

    snd_status_monitor dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq),
        .in_port   (in_port)
    );

    always #5 clk = ~clk;

    // Reference model state: inputs seen two clocks late, and for each bit how many
    // cycles the late input has disagreed with the accepted value.
    logic [4:0]  m_s1, m_s2, m_stable, m_mask, m_edge, m_nxt, m_edges, m_w1c;
    int          m_run [5];
    int          m_L;
    bit          m_irq;
    bit          m_rd_valid;
    bit          m_live = 1'b0;
    logic [31:0] m_rd_hold;
    logic [31:0] exp_q [$];

    function automatic logic [31:0] reg_value(input logic [1:0] a);
        case (a)
            2'd0:    return {27'b0, m_stable};
            2'd1:    return {27'b0, m_mask};
            2'd2:    return {27'b0, m_edge};
            default: return 32'(m_L);
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0; m_mask = '0; m_edge = '0;
            m_L = 1000; m_irq = 1'b0; m_rd_valid = 1'b0; m_rd_hold = '0;
            for (int i = 0; i < 5; i++) m_run[i] = 0;
            exp_q.delete();
            m_live = 1'b1;
        end else if (m_live) begin
            m_rd_valid = read;
            if (read) exp_q.push_back(reg_value(address));
            m_nxt = m_stable;
            for (int i = 0; i < 5; i++) begin
                if (m_s2[i] != m_stable[i]) begin
                    if (m_run[i] >= m_L) begin
                        m_nxt[i] = m_s2[i];
                        m_run[i] = 0;
                    end else begin
                        m_run[i] = m_run[i] + 1;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_edges  = m_nxt ^ m_stable;
            m_stable = m_nxt;
            m_w1c    = '0;
            if (write) begin
                case (address)
                    2'd1:    m_mask = writedata[4:0];
                    2'd2:    m_w1c  = writedata[4:0];
                    2'd3:    m_L    = int'(writedata[15:0]);
                    default: ;
                endcase
            end
            m_edge = (m_edge & ~m_w1c) | m_edges;
            m_irq  = |(m_edge & m_mask);
            m_s2   = m_s1;
            m_s1   = in_port;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_live) begin
            check("irq", {31'b0, irq}, {31'b0, m_irq});
            if (m_rd_valid) begin
                if (exp_q.size() == 0) begin
                    check("readdata_no_expect", readdata, 32'hDEAD_BEEF);
                end else begin
                    m_rd_hold = exp_q.pop_front();
                    check("readdata", readdata, m_rd_hold);
                end
            end else begin
                check("readdata_hold", readdata, m_rd_hold);
            end
        end
    end

    task automatic bus(input bit rd, input bit wr, input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        read = rd; write = wr; address = a; writedata = d;
    endtask

    task automatic idle(input int n);
        repeat (n) bus(1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    task automatic rd(input logic [1:0] a);
        bus(1'b1, 1'b0, a, 32'd0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus(1'b0, 1'b1, a, d);
    endtask

    task automatic apply_reset(input int n);
        @(negedge clk);
        reset = 1'b1; read = 1'b0; write = 1'b0;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        int          r;
        logic [1:0]  a;
        reset = 1'b1; in_port = '0; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
        apply_reset(3);

        // Reset values of every register.
        for (int i = 0; i < 4; i++) rd(2'(i));
        idle(3);

        // Rising edge on bit 2 with limit 4, DATA polled every cycle.
        wr(2'd3, 32'd4);
        in_port[2] = 1'b1;
        for (int i = 0; i < 10; i++) rd(2'd0);
        rd(2'd2);

        // Three-cycle glitch on bit 0 never commits.
        idle(1);
        in_port[0] = 1'b1;
        idle(2);
        in_port[0] = 1'b0;
        for (int i = 0; i < 12; i++) rd(2'(i % 3));

        // Mask, W1C clear of bit 2, W1C of an unrelated bit.
        wr(2'd1, 32'hFFFF_FFE4);
        idle(2);
        wr(2'd2, 32'h4);
        idle(2);
        wr(2'd1, 32'h0C);
        wr(2'd2, 32'h1);
        rd(2'd2);

        // W1C of bit 3 on the same clock its stable value toggles.
        idle(1);
        in_port[3] = 1'b1;
        idle(5);
        wr(2'd2, 32'h8);
        rd(2'd2);
        idle(2);
        rd(2'd2);

        // Limit lowered mid-count, then reset mid-count.
        wr(2'd3, 32'd100);
        in_port[1] = 1'b1;
        idle(52);
        wr(2'd3, 32'd10);
        for (int i = 0; i < 4; i++) rd(2'd0);
        wr(2'd3, 32'd100);
        in_port[4] = 1'b1;
        idle(20);
        apply_reset(2);
        for (int i = 0; i < 4; i++) rd(2'(i));

        // Inputs held high out of reset rise after the default limit.
        in_port = 5'h1F;
        apply_reset(2);
        for (int i = 0; i < 1010; i++) rd((i % 8 == 7) ? 2'd2 : 2'd0);

        // Randomised traffic with short limits so edges actually commit.
        apply_reset(2);
        in_port = '0;
        wr(2'd3, 32'd2);
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 5; b++) if ($urandom_range(0, 99) < 4) in_port[b] = ~in_port[b];
            r = $urandom_range(0, 99);
            a = 2'($urandom_range(0, 3));
            d = $urandom();
            if (r < 40)      rd(a);
            else if (r < 46) wr(2'd1, d);
            else if (r < 53) wr(2'd2, d);
            else if (r < 56) wr(2'd3, (d & 32'hFFFF_0000) | 32'($urandom_range(0, 6)));
            else if (r < 60) bus(1'b1, 1'b1, a, (a == 2'd3) ? 32'($urandom_range(0, 6)) : d);
            else             idle(1);
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
